morse_key_decoder: RTL
======================

Name: morse_key_decoder

Overview:
- Front end of the Morse path: samples the operator key, classifies each press as dot or dash by duration, and detects the inter-letter gap.
- On each gap, decodes the accumulated symbol pattern into the 6-bit letter code and the display-enable consumed by the VGA display top (lett/vgaon).
- Holds the last decoded letter stable for the display until the next letter completes.

Parameters:
- TICK_DIV, 100000, clk cycles per timing tick (1 ms at 100 MHz).
- MIN_PRESS_TICKS, 20, presses shorter than this are glitches and are discarded.
- DASH_TICKS, 300, press length at or above which the symbol is a dash (below is a dot).
- LETTER_GAP_TICKS, 700, released time that ends a letter.
- MAX_SYMBOLS, 5, longest valid pattern.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- key  input  1  raw key level (1 = pressed), asynchronous to clk.
- lett  output  6  last decoded letter code.
- vgaon  output  1  display enable: 1 while lett holds a valid letter.
- letter_stb  output  1  one-cycle pulse when lett/vgaon update.
- dot_led  output  1  one-cycle pulse when a dot is accepted.
- dash_led  output  1  one-cycle pulse when a dash is accepted.

Behaviour:
- Reset values: lett=0, vgaon=0, letter_stb=0, dot_led=0, dash_led=0, FSM=IDLE, pattern and counters cleared, synchronizer flops cleared. A reset mid-press or mid-gap discards the partial letter and emits no strobe.
- Input synchronization: key passes through a 2-flop synchronizer (ks). Rise and fall edges are detected on ks against its previous value, so edge detection lags key by 3 clk.
- Tick prescaler: free-running counter 0..TICK_DIV-1. tick is high for 1 cycle at wrap.
- Duration counter: zeroed on every ks edge, increments on tick, saturates at all-ones. Width covers LETTER_GAP_TICKS.
- Symbol store: pattern[MAX_SYMBOLS-1:0] shifts left with the new bit in the LSB (1 = dash, 0 = dot). Count cnt[2:0]. An overflow flag ovf is set when a symbol arrives with cnt==MAX_SYMBOLS.
- FSM states:
  - IDLE: wait for ks rise, then go to PRESS. The duration counter is ignored.
  - PRESS: on ks fall, evaluate the duration d.
    - d < MIN_PRESS_TICKS: discard. Return to GAP if cnt>0 or ovf, else to IDLE.
    - MIN_PRESS_TICKS <= d < DASH_TICKS: dot. Pulse dot_led and shift in 0.
    - d >= DASH_TICKS: dash. Pulse dash_led and shift in 1.
    - After an accepted symbol, go to GAP.
  - GAP: ks rise goes to PRESS; the letter continues. Duration == LETTER_GAP_TICKS (reached on a tick) goes to EMIT. A rise and the threshold in the same cycle resolve to PRESS.
  - EMIT: lasts 1 cycle. Update lett/vgaon, pulse letter_stb, clear pattern/cnt/ovf, then go to IDLE.
- Decode in EMIT:
  - Letters A..Z give 0..25 (International Morse).
  - Digits 0..9 give 26..35 (five-symbol codes; "-----" gives 26).
  - A valid code sets lett=code and vgaon=1.
  - An unmapped pattern or ovf sets lett=6'd63 and vgaon=0.
- Outputs change only in EMIT or reset. letter_stb, dot_led and dash_led are never high for 2 consecutive cycles.
- A key held indefinitely stays in PRESS with the counter saturated, and classifies as a dash on release.

Test Plan:
All scenarios use TICK_DIV=4, MIN_PRESS_TICKS=1, DASH_TICKS=3, LETTER_GAP_TICKS=6, with press/release lengths given in ticks.
- Dot(1) gap(2) dash(4) gap(8) -> dot_led then dash_led pulses; one letter_stb; lett=0 ("A"), vgaon=1; lett holds through an idle period of 50 cycles.
- Dash, dot, dot, dot with 2-tick gaps, then a 6-tick gap -> lett=1 ("B"). A following "-----" -> lett=26, vgaon=1, exactly one letter_stb per letter.
- Six dots, then a gap -> lett=63, vgaon=0, a single letter_stb; the next valid "E" (single dot) -> lett=4, vgaon=1.
- A press shorter than 1 tick (2 clk) between letters -> no dot_led, no letter_stb, lett unchanged.
- Assert reset during the 2nd symbol of "-.-" -> all outputs 0 the next cycle, no letter_stb. A fresh "." after reset -> lett=4.
- Key released for exactly 5 ticks between dots, then 6 ticks -> one letter "I" (lett=8), not two "E"s.

Source files
------------

// File: rtl/morse_key_decoder.sv
// morse_key_decoder: Morse key front end. Synchronizes the raw key, times
// each press against a millisecond-scale tick to classify dot or dash, and
// closes a letter when the key stays released long enough. Each closed
// letter is decoded into a 6-bit code that the display holds until the next
// letter completes.
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   key        raw key level, 1 = pressed, asynchronous to clk
//   lett       last decoded letter code (A..Z = 0..25, 0..9 = 26..35, 63 = invalid)
//   vgaon      display enable, 1 while lett holds a valid letter
//   letter_stb one-cycle pulse when lett/vgaon update
//   dot_led    one-cycle pulse when a dot is accepted
//   dash_led   one-cycle pulse when a dash is accepted
module morse_key_decoder #(
   parameter int unsigned TICK_DIV         = 100000,
   parameter int unsigned MIN_PRESS_TICKS  = 20,
   parameter int unsigned DASH_TICKS       = 300,
   parameter int unsigned LETTER_GAP_TICKS = 700,
   parameter int unsigned MAX_SYMBOLS      = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key,
   output logic [5:0] lett,
   output logic       vgaon,
   output logic       letter_stb,
   output logic       dot_led,
   output logic       dash_led
);

   localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned MAX_A  = (MIN_PRESS_TICKS > DASH_TICKS) ? MIN_PRESS_TICKS : DASH_TICKS;
   localparam int unsigned MAX_T  = (MAX_A > LETTER_GAP_TICKS) ? MAX_A : LETTER_GAP_TICKS;
   localparam int unsigned DUR_W  = $clog2(MAX_T + 1);
   localparam int unsigned CNT_W  = $clog2(MAX_SYMBOLS + 1);
   localparam int unsigned LETT_W = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESS,
      ST_GAP,
      ST_EMIT
   } state_t;

   state_t                   state, state_nxt;
   logic                     key_meta, ks, ks_d;
   logic                     rise_c, fall_c, tick_c;
   logic [TICK_W-1:0]        tick_cnt;
   logic [DUR_W-1:0]         dur;
   logic [MAX_SYMBOLS-1:0]   pattern;
   logic [CNT_W-1:0]         cnt;
   logic                     ovf;
   logic                     sym_push, sym_bit, clr_pat;
   logic [LETT_W-1:0]        lett_nxt;
   logic                     vgaon_nxt, stb_nxt, dot_nxt, dash_nxt;
   logic [LETT_W:0]          dec_c;

   // Pattern to letter code; MSB of the result flags a mapped pattern.
   // The first symbol keyed sits in the most significant used bit.
   function automatic logic [LETT_W:0] decode(input logic [CNT_W-1:0] c,
                                              input logic [MAX_SYMBOLS-1:0] p);
      logic [7:0] k;
      k = {3'(c), 5'(p)};
      case (k)
         8'b010_00001: decode = {1'b1, 6'd0};   // A .-
         8'b100_01000: decode = {1'b1, 6'd1};   // B -...
         8'b100_01010: decode = {1'b1, 6'd2};   // C -.-.
         8'b011_00100: decode = {1'b1, 6'd3};   // D -..
         8'b001_00000: decode = {1'b1, 6'd4};   // E .
         8'b100_00010: decode = {1'b1, 6'd5};   // F ..-.
         8'b011_00110: decode = {1'b1, 6'd6};   // G --.
         8'b100_00000: decode = {1'b1, 6'd7};   // H ....
         8'b010_00000: decode = {1'b1, 6'd8};   // I ..
         8'b100_00111: decode = {1'b1, 6'd9};   // J .---
         8'b011_00101: decode = {1'b1, 6'd10};  // K -.-
         8'b100_00100: decode = {1'b1, 6'd11};  // L .-..
         8'b010_00011: decode = {1'b1, 6'd12};  // M --
         8'b010_00010: decode = {1'b1, 6'd13};  // N -.
         8'b011_00111: decode = {1'b1, 6'd14};  // O ---
         8'b100_00110: decode = {1'b1, 6'd15};  // P .--.
         8'b100_01101: decode = {1'b1, 6'd16};  // Q --.-
         8'b011_00010: decode = {1'b1, 6'd17};  // R .-.
         8'b011_00000: decode = {1'b1, 6'd18};  // S ...
         8'b001_00001: decode = {1'b1, 6'd19};  // T -
         8'b011_00001: decode = {1'b1, 6'd20};  // U ..-
         8'b100_00001: decode = {1'b1, 6'd21};  // V ...-
         8'b011_00011: decode = {1'b1, 6'd22};  // W .--
         8'b100_01001: decode = {1'b1, 6'd23};  // X -..-
         8'b100_01011: decode = {1'b1, 6'd24};  // Y -.--
         8'b100_01100: decode = {1'b1, 6'd25};  // Z --..
         8'b101_11111: decode = {1'b1, 6'd26};  // 0 -----
         8'b101_01111: decode = {1'b1, 6'd27};  // 1 .----
         8'b101_00111: decode = {1'b1, 6'd28};  // 2 ..---
         8'b101_00011: decode = {1'b1, 6'd29};  // 3 ...--
         8'b101_00001: decode = {1'b1, 6'd30};  // 4 ....-
         8'b101_00000: decode = {1'b1, 6'd31};  // 5 .....
         8'b101_10000: decode = {1'b1, 6'd32};  // 6 -....
         8'b101_11000: decode = {1'b1, 6'd33};  // 7 --...
         8'b101_11100: decode = {1'b1, 6'd34};  // 8 ---..
         8'b101_11110: decode = {1'b1, 6'd35};  // 9 ----.
         default:      decode = {1'b0, 6'd63};
      endcase
   endfunction

   // Two-flop synchronizer plus previous-value flop for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         key_meta <= 1'b0;
         ks       <= 1'b0;
         ks_d     <= 1'b0;
      end else begin
         key_meta <= key;
         ks       <= key_meta;
         ks_d     <= ks;
      end
   end

   assign rise_c = ks & ~ks_d;
   assign fall_c = ~ks & ks_d;

   // Free-running tick prescaler.
   assign tick_c = (tick_cnt == TICK_W'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset || tick_c) tick_cnt <= '0;
      else                 tick_cnt <= tick_cnt + TICK_W'(1);
   end

   // Ticks since the last key edge; an edge wins over a coincident tick.
   always_ff @(posedge clk) begin
      if (reset || rise_c || fall_c) dur <= '0;
      else if (tick_c && (dur != '1)) dur <= dur + DUR_W'(1);
   end

   // Symbol store; symbols beyond the limit only raise the overflow flag.
   always_ff @(posedge clk) begin
      if (reset || clr_pat) begin
         pattern <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
      end else if (sym_push) begin
         if (cnt == CNT_W'(MAX_SYMBOLS)) begin
            ovf <= 1'b1;
         end else begin
            pattern <= {pattern[MAX_SYMBOLS-2:0], sym_bit};
            cnt     <= cnt + CNT_W'(1);
         end
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         lett       <= '0;
         vgaon      <= 1'b0;
         letter_stb <= 1'b0;
         dot_led    <= 1'b0;
         dash_led   <= 1'b0;
      end else begin
         state      <= state_nxt;
         lett       <= lett_nxt;
         vgaon      <= vgaon_nxt;
         letter_stb <= stb_nxt;
         dot_led    <= dot_nxt;
         dash_led   <= dash_nxt;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_nxt = state;
      lett_nxt  = lett;
      vgaon_nxt = vgaon;
      stb_nxt   = 1'b0;
      dot_nxt   = 1'b0;
      dash_nxt  = 1'b0;
      sym_push  = 1'b0;
      sym_bit   = 1'b0;
      clr_pat   = 1'b0;
      dec_c     = decode(cnt, pattern);
      case (state)
         ST_IDLE: begin
            if (rise_c) state_nxt = ST_PRESS;
         end
         ST_PRESS: begin
            if (fall_c) begin
               if (dur < DUR_W'(MIN_PRESS_TICKS)) begin
                  // Glitch: resume the letter in progress, if any.
                  state_nxt = ((cnt != '0) || ovf) ? ST_GAP : ST_IDLE;
               end else if (dur < DUR_W'(DASH_TICKS)) begin
                  dot_nxt   = 1'b1;
                  sym_push  = 1'b1;
                  state_nxt = ST_GAP;
               end else begin
                  dash_nxt  = 1'b1;
                  sym_push  = 1'b1;
                  sym_bit   = 1'b1;
                  state_nxt = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            // A new press takes priority over the letter-gap threshold.
            if (rise_c)                                 state_nxt = ST_PRESS;
            else if (dur == DUR_W'(LETTER_GAP_TICKS))   state_nxt = ST_EMIT;
         end
         ST_EMIT: begin
            stb_nxt = 1'b1;
            clr_pat = 1'b1;
            if (dec_c[LETT_W] && !ovf) begin
               lett_nxt  = dec_c[LETT_W-1:0];
               vgaon_nxt = 1'b1;
            end else begin
               lett_nxt  = 6'd63;
               vgaon_nxt = 1'b0;
            end
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule
